iob_pad_ctrl: RTL
=================

IOB_PAD_CTRL -- requirements
Module: iob_pad_ctrl

Interface
REQ-001 The block SHALL have parameter TA_CYC, default 2, giving the input-to-drive turnaround cycles with the pad released; legal range 0..15.
REQ-002 The block SHALL have parameter FILT_LEN, default 4, giving the consecutive stable cycles the glitch filter requires; legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port out_en, input, 1 bit: request to drive the pad.
REQ-006 Port out_data, input, 1 bit: value to drive while driving.
REQ-007 Port pad_o, input, 1 bit: raw pad value from the tri-state buffer output; asynchronous to clk.
REQ-008 Port pad_i, output, 1 bit: value to the tri-state buffer data input.
REQ-009 Port pad_t, output, 1 bit: tri-state control to the buffer; 1 releases the pad, 0 drives it.
REQ-010 Port drive_active, output, 1 bit: high exactly while pad_t is 0.
REQ-011 Port in_data, output, 1 bit: synchronised, optionally filtered, pad value.
REQ-012 Port in_rise, output, 1 bit: single-cycle pulse on an in_data 0->1 change.
REQ-013 Port in_fall, output, 1 bit: single-cycle pulse on an in_data 1->0 change.

Function
REQ-014 Direction FSM states SHALL be: RELEASE (pad_t=1), TURN (pad_t=1), DRIVE (pad_t=0).
REQ-015 RELEASE with out_en=1 SHALL go to TURN if TA_CYC>0, otherwise directly to DRIVE.
REQ-016 TURN SHALL last exactly TA_CYC cycles, then go to DRIVE, provided out_en stays 1.
REQ-017 out_en=0 in TURN or DRIVE SHALL cause a return to RELEASE on the next edge; the turnaround counter SHALL clear.
REQ-018 pad_t and drive_active SHALL be registered state decodes; pad_t=0 first appears TA_CYC+1 edges after out_en is sampled high.
REQ-019 pad_i SHALL be out_data registered every cycle, regardless of state.
REQ-020 pad_o SHALL pass through a two-flop synchroniser before any other use.
REQ-021 in_rise/in_fall SHALL be high for exactly the first cycle in_data holds its new value; never both high together.
REQ-022 The input path SHALL operate in all FSM states, so a driven pad reads back through in_data.

Reset
REQ-023 While rst_n=0, asynchronously: FSM=RELEASE, pad_t=1, drive_active=0, pad_i=0, in_data=0, in_rise=0, in_fall=0, synchroniser and all counters 0.
REQ-024 Reset asserted during DRIVE SHALL release the pad (pad_t=1) without waiting for a clock edge.
REQ-025 After rst_n deasserts, a pad held at 1 SHALL produce one in_rise pulse when in_data first becomes 1.

Configuration
REQ-026 Macro IOB_PAD_FILTER_EN SHALL compile in the glitch filter.
REQ-027 With the macro defined: a filter counter SHALL increment while the synchroniser output differs from in_data and clear whenever they are equal; in_data SHALL toggle when the counter reaches FILT_LEN, and the counter then clears.
REQ-028 With the macro defined: pad-change-to-in_data latency SHALL be 2+FILT_LEN edges; pulses shorter than FILT_LEN synchronised cycles SHALL be rejected.
REQ-029 Without the macro: in_data SHALL equal the synchroniser output, registered once (latency 3 edges); FILT_LEN SHALL be ignored and no filter logic inferred.

Verification
REQ-030 TA_CYC=2, out_en 0->1 at edge N -> pad_t=0 and drive_active=1 from edge N+3; pad_i follows out_data with 1-cycle lag.
REQ-031 TA_CYC=2, out_en pulsed high for 1 cycle -> pad_t stays 1 throughout; FSM back in RELEASE.
REQ-032 TA_CYC=0, out_en 0->1 -> pad_t=0 after 1 edge; out_en 1->0 -> pad_t=1 after 1 edge.
REQ-033 Filter enabled, FILT_LEN=4: pad_o high for 3 cycles -> no in_data change and no pulses; high for 10 cycles -> in_data=1 after 6 edges, one in_rise pulse.
REQ-034 Filter disabled: pad_o 0->1->0 with 5-cycle spacing -> in_rise then in_fall, each 1 cycle, each 3 edges after its pad change.
REQ-035 rst_n asserted mid-DRIVE between edges -> pad_t=1 immediately; all outputs at reset values until after rst_n release.

Source files
------------

// File: rtl/iob_pad_ctrl.sv
// Bidirectional pad controller: direction FSM with turnaround, synchronised input path.
// Define IOB_PAD_FILTER_EN to compile in the input glitch filter.
module iob_pad_ctrl #(
  parameter int unsigned TA_CYC   = 2,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic out_en,
  input  logic out_data,
  input  logic pad_o,
  output logic pad_i,
  output logic pad_t,
  output logic drive_active,
  output logic in_data,
  output logic in_rise,
  output logic in_fall
);

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    TURN    = 2'd1,
    DRIVE   = 2'd2
  } dir_e;

  localparam logic [3:0] TA_LAST =
    (TA_CYC > 0) ? 4'(TA_CYC - 1) : 4'd0;

  if (TA_CYC > 15) begin : g_ta_range
    $error("iob_pad_ctrl: TA_CYC must be 0..15");
  end

  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_filt_range
    $error("iob_pad_ctrl: FILT_LEN must be 1..255");
  end

  dir_e       state_q, state_d;
  logic [3:0] ta_cnt_q, ta_cnt_d;
  logic       pad_t_q, pad_t_d;
  logic       drv_q, drv_d;
  logic       pad_i_q, pad_i_d;

  logic       sync1_q, sync2_q;
  logic       in_q, in_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // Direction FSM: next state and turnaround count
  always_comb begin
    state_d  = state_q;
    ta_cnt_d = ta_cnt_q;
    unique case (state_q)
      RELEASE: begin
        ta_cnt_d = '0;
        if (out_en) begin
          state_d = (TA_CYC > 0) ? TURN : DRIVE;
        end
      end
      TURN: begin
        if (!out_en) begin
          state_d  = RELEASE;
          ta_cnt_d = '0;
        end else if (ta_cnt_q == TA_LAST) begin
          state_d  = DRIVE;
          ta_cnt_d = '0;
        end else begin
          ta_cnt_d = ta_cnt_q + 4'd1;
        end
      end
      DRIVE: begin
        ta_cnt_d = '0;
        if (!out_en) begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d  = RELEASE;
        ta_cnt_d = '0;
      end
    endcase
  end

  // Pad control decodes are registered from the current state
  always_comb begin
    pad_t_d = (state_q != DRIVE);
    drv_d   = (state_q == DRIVE);
    pad_i_d = out_data;
  end

  // Direction and output-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RELEASE;
      ta_cnt_q <= '0;
      pad_t_q  <= 1'b1;
      drv_q    <= 1'b0;
      pad_i_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ta_cnt_q <= ta_cnt_d;
      pad_t_q  <= pad_t_d;
      drv_q    <= drv_d;
      pad_i_q  <= pad_i_d;
    end
  end

  // Two-flop synchroniser for the asynchronous pad value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_o;
      sync2_q <= sync1_q;
    end
  end

`ifdef IOB_PAD_FILTER_EN
  localparam logic [7:0] FILT_MAX = 8'(FILT_LEN);

  logic [7:0] filt_q, filt_d;

  // Glitch filter: count consecutive disagreeing cycles, flip on reaching length
  always_comb begin
    filt_d = '0;
    in_d   = in_q;
    if (sync2_q != in_q) begin
      if (filt_q + 8'd1 == FILT_MAX) begin
        in_d = ~in_q;
      end else begin
        filt_d = filt_q + 8'd1;
      end
    end
  end

  // Filter counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  // Unfiltered: the synchroniser output is registered once more
  always_comb begin
    in_d = sync2_q;
  end
`endif

  // Edge detection against the current in_data value
  always_comb begin
    rise_d = in_d & ~in_q;
    fall_d = ~in_d & in_q;
  end

  // Input data and edge pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      in_q   <= in_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign pad_t        = pad_t_q;
  assign drive_active = drv_q;
  assign pad_i        = pad_i_q;
  assign in_data      = in_q;
  assign in_rise      = rise_q;
  assign in_fall      = fall_q;

endmodule
